// File: rtl/cnot_cascade_sequencer_if.sv
// Gate-program load port for cnot_cascade_sequencer.
// Toffoli fields exist only with CNOT_SEQ_TOFFOLI_EN.
interface cnot_cascade_sequencer_if #(
  parameter int WIDTH = 8
);
  localparam int IW = $clog2(WIDTH);

  logic          prog_valid;
  logic          prog_ready;
  logic [IW-1:0] prog_ctrl;
  logic [IW-1:0] prog_tgt;
`ifdef CNOT_SEQ_TOFFOLI_EN
  logic [IW-1:0] prog_ctrl2;
  logic          prog_c2_en;
`endif

  modport master (
    output prog_valid,
    output prog_ctrl,
    output prog_tgt,
`ifdef CNOT_SEQ_TOFFOLI_EN
    output prog_ctrl2,
    output prog_c2_en,
`endif
    input  prog_ready
  );

  modport slave (
    input  prog_valid,
    input  prog_ctrl,
    input  prog_tgt,
`ifdef CNOT_SEQ_TOFFOLI_EN
    input  prog_ctrl2,
    input  prog_c2_en,
`endif
    output prog_ready
  );
endinterface

// File: rtl/cnot_cascade_sequencer.sv
// Programmable CNOT cascade, run forward or in reverse.
// Optional Toffoli entries: define CNOT_SEQ_TOFFOLI_EN.
module cnot_cascade_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int IW = $clog2(WIDTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  cnot_cascade_sequencer_if.slave   prog,
  input  logic                      prog_clear,
  input  logic                      start,
  input  logic                      dir,
  input  logic [WIDTH-1:0]          data_in,
  output logic [WIDTH-1:0]          data_out,
  output logic                      busy,
  output logic                      done,
  output logic [CW-1:0]             gate_count,
  output logic                      err
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [CW-1:0]    count_q;
  logic [PW-1:0]    ptr_q;
  logic             dir_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic [IW-1:0]    ctrl_mem_q [DEPTH];
  logic [IW-1:0]    tgt_mem_q  [DEPTH];
`ifdef CNOT_SEQ_TOFFOLI_EN
  logic [IW-1:0]    ctrl2_mem_q [DEPTH];
  logic             c2en_mem_q  [DEPTH];
`endif

  logic             ready;
  logic             fire;
  logic             gate_ok;
  logic             wr_en;
  logic [CW-1:0]    last_idx;
  logic             at_last;
  logic [IW-1:0]    g_ctrl;
  logic [IW-1:0]    g_tgt;
  logic             c2_bit;

  assign ready = (state_q == S_IDLE) && !start && !prog_clear
               && (count_q < CW'(DEPTH));
  assign prog.prog_ready = ready;
  assign fire  = prog.prog_valid && ready;

  // Gate legality: distinct, in-range bit indices
  always_comb begin
    gate_ok = (prog.prog_ctrl != prog.prog_tgt)
            && ({1'b0, prog.prog_ctrl} < (IW+1)'(WIDTH))
            && ({1'b0, prog.prog_tgt}  < (IW+1)'(WIDTH));
`ifdef CNOT_SEQ_TOFFOLI_EN
    if (prog.prog_c2_en) begin
      gate_ok = gate_ok
              && (prog.prog_ctrl2 != prog.prog_tgt)
              && (prog.prog_ctrl2 != prog.prog_ctrl)
              && ({1'b0, prog.prog_ctrl2} < (IW+1)'(WIDTH));
    end
`endif
  end

  assign wr_en = fire && gate_ok && !rst;

  // Program memory write; entries are never erased
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ctrl_mem_q[count_q[PW-1:0]] <= prog.prog_ctrl;
      tgt_mem_q[count_q[PW-1:0]]  <= prog.prog_tgt;
`ifdef CNOT_SEQ_TOFFOLI_EN
      ctrl2_mem_q[count_q[PW-1:0]] <= prog.prog_ctrl2;
      c2en_mem_q[count_q[PW-1:0]]  <= prog.prog_c2_en;
`endif
    end
  end

  assign last_idx = count_q - CW'(1);
  assign at_last  = dir_q ? (ptr_q == '0)
                          : (CW'(ptr_q) == last_idx);
  assign g_ctrl   = ctrl_mem_q[ptr_q];
  assign g_tgt    = tgt_mem_q[ptr_q];

`ifdef CNOT_SEQ_TOFFOLI_EN
  assign c2_bit = c2en_mem_q[ptr_q] ? data_q[ctrl2_mem_q[ptr_q]] : 1'b1;
`else
  assign c2_bit = 1'b1;
`endif

  // Shared gate datapath: tgt ^= ctrl (& ctrl2)
  always_comb begin
    data_d = data_q;
    data_d[g_tgt] = data_q[g_tgt] ^ (data_q[g_ctrl] & c2_bit);
  end

  // Control FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      count_q <= '0;
      ptr_q   <= '0;
      dir_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (prog_clear) begin
            count_q <= '0;
            err_q   <= 1'b0;
          end else if (start) begin
            data_q <= data_in;
            dir_q  <= dir;
            if (count_q != '0) begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              ptr_q   <= dir ? last_idx[PW-1:0] : '0;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end else if (fire) begin
            if (gate_ok) begin
              count_q <= count_q + CW'(1);
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          data_q <= data_d;
          if (at_last) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            ptr_q <= dir_q ? ptr_q - PW'(1) : ptr_q + PW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign gate_count = count_q;
  assign err        = err_q;
endmodule
